tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
Time-division demultiplexer, the receive end of a 4-channel TDM link whose transmit side uses a 2-bit select to place four channels onto one wire. Takes a serial bit stream with a frame-sync marker and steers each bit into the shadow register of the channel whose slot is active. When a frame completes, it publishes all four channel words in parallel with a one-cycle valid strobe. It also tracks frame alignment and flags sync errors.

Parameters:
W, 4, bits per channel slot (W >= 1); frame length = 4*W accepted bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
din  input  1  serial data bit, MSB of each channel word first
din_valid  input  1  din and frame_sync are sampled only when 1
frame_sync  input  1  marks the first bit of channel 0 (frame start); qualified by din_valid
dout  output  4*W  channel k word on dout[k*W +: W], registered
frame_valid  output  1  one-cycle pulse: dout updated with a complete frame
locked  output  1  1 while in LOCKED state
sync_err  output  1  one-cycle pulse on an alignment violation

Behaviour:
- Reset (rst_n=0 at posedge): state=HUNT, slot=0, bit_cnt=0, shadow regs=0, dout=0, frame_valid=0, locked=0, sync_err=0. Reset mid-frame discards the partial frame.
- "Accepted bit" means din_valid=1 at posedge. With din_valid=0, all counters, shadows and dout hold, and the pulses deassert.
- Position (slot, bit_cnt): slot 0..3 (2 bits), bit_cnt 0..W-1. Advance per accepted bit: bit_cnt+1; at W-1, bit_cnt wraps to 0 and slot+1; slot 3 wraps to 0.
- Shadow load: shadow[slot] <= {shadow[slot][W-2:0], din} (MSB-first shift). For W=1, shadow[slot] <= din.
- States:
  - HUNT:
    - Accepted bit with frame_sync=0: discarded, nothing changes.
    - Accepted bit with frame_sync=1: clear all shadows, load bit at position (0,0), advance, go LOCKED (locked=1 from the next cycle).
  - LOCKED, accepted bit at expected position (0,0):
    - frame_sync=1: normal; load and advance.
    - frame_sync=0: sync_err pulse, bit discarded, go HUNT, locked=0, slot/bit_cnt=0.
  - LOCKED, accepted bit at any other position:
    - frame_sync=0: normal; load and advance.
    - frame_sync=1: sync_err pulse, partial frame discarded (shadows cleared), bit loaded as position (0,0), position becomes (0,1) (or (1,0) if W=1). Stay LOCKED. dout is not updated.
- Frame completion: the accepted bit at position (3,W-1) with frame_sync=0, while LOCKED. On that same edge, dout <= all four shadow words including this final bit, and frame_valid=1 for exactly one cycle. Latency is zero cycles after the edge that samples the last bit. Position wraps to (0,0).
- dout holds its last complete frame through HUNT, errors and idle; only frame completion or reset changes it.
- frame_valid and sync_err are never both 1 in the same cycle.
- locked reflects the registered state only; it changes on the cycle after the transition edge.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with din_valid=1 and random din -> dout=0, frame_valid=0, locked=0, sync_err=0.
- Clean frame (W=4): frame_sync on first bit, stream 16 bits 0xA,0x5,0xF,0x3 MSB-first back-to-back -> after the 16th edge dout=16'h3F5A, frame_valid high for 1 cycle, locked=1.
- Gapped input: same frame with din_valid=0 inserted for 3 cycles after every bit -> identical dout=16'h3F5A, single frame_valid pulse, no change during gaps.
- Early sync: after 6 bits of a frame, assert frame_sync with new frame 0x1,0x2,0x4,0x8 -> sync_err pulse on that edge, dout keeps previous value, then dout=16'h8421 with frame_valid after 16 more bits.
- Missing sync: second frame starts without frame_sync -> sync_err pulse, locked drops to 0, following bits ignored until frame_sync. Resync then delivers the correct frame.
- Reset mid-frame: rst_n=0 after 9 bits of a frame, then a full frame 0xC,0x0,0x0,0x1 -> dout=16'h100C, no stale bits from the aborted frame.

Source files
------------

// File: rtl/tdm_demux4_if.sv
// Bundle of the serial input and parallel output signals of the TDM demultiplexer.
// master: the side that drives the serial stream and watches the results.
// slave:  the demultiplexer.
interface tdm_demux4_if #(
  parameter int W = 4
);
  logic           din;
  logic           din_valid;
  logic           frame_sync;
  logic [4*W-1:0] dout;
  logic           frame_valid;
  logic           locked;
  logic           sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  dout, frame_valid, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, frame_valid, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// Receive end of a 4-channel TDM link. Serial bits are shifted MSB-first into
// the shadow word of the active slot. A completed frame is published on dout
// with a one-cycle frame_valid strobe. A HUNT/LOCKED tracker follows frame
// alignment and pulses sync_err whenever frame_sync disagrees with the
// expected frame position.
module tdm_demux4 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] BIT_LAST   = CW'(W - 1);
  // Position right after a bit has been placed at (0,0).
  localparam logic [1:0]    START_SLOT = (W == 1) ? 2'd1 : 2'd0;
  localparam logic [CW-1:0] START_BIT  = (W == 1) ? '0 : CW'(1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             slot_q, slot_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [3:0][W-1:0]      shadow_q, shadow_d;
  logic [3:0][W-1:0]      dout_q, dout_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   sync_err_q, sync_err_d;

  logic [W-1:0]           shifted;
  logic [1:0]             adv_slot;
  logic [CW-1:0]          adv_bit;
  logic                   at_start;
  logic                   at_end;

  // Alignment tracking, shadow loading and frame publication for one accepted bit.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    bit_cnt_d     = bit_cnt_q;
    shadow_d      = shadow_q;
    dout_d        = dout_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    // Active slot word with the incoming bit appended at the LSB end.
    shifted  = (shadow_q[slot_q] << 1) | W'(bus.din);
    at_start = (slot_q == 2'd0) && (bit_cnt_q == '0);
    at_end   = (slot_q == 2'd3) && (bit_cnt_q == BIT_LAST);

    if (bit_cnt_q == BIT_LAST) begin
      adv_bit  = '0;
      adv_slot = slot_q + 2'd1;
    end else begin
      adv_bit  = bit_cnt_q + CW'(1);
      adv_slot = slot_q;
    end

    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          // Only a frame start gets us out of HUNT; everything else is dropped.
          if (bus.frame_sync) begin
            shadow_d    = '0;
            shadow_d[0] = W'(bus.din);
            slot_d      = START_SLOT;
            bit_cnt_d   = START_BIT;
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (at_start) begin
            if (bus.frame_sync) begin
              shadow_d[slot_q] = shifted;
              slot_d           = adv_slot;
              bit_cnt_d        = adv_bit;
            end else begin
              // Expected frame start never arrived: lose lock.
              sync_err_d = 1'b1;
              state_d    = HUNT;
              slot_d     = 2'd0;
              bit_cnt_d  = '0;
            end
          end else if (!bus.frame_sync) begin
            shadow_d[slot_q] = shifted;
            slot_d           = adv_slot;
            bit_cnt_d        = adv_bit;
            if (at_end) begin
              dout_d        = shadow_d;
              frame_valid_d = 1'b1;
            end
          end else begin
            // Frame start arrived early: realign on it and drop the partial frame.
            sync_err_d  = 1'b1;
            shadow_d    = '0;
            shadow_d[0] = W'(bus.din);
            slot_d      = START_SLOT;
            bit_cnt_d   = START_BIT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State, position, shadow and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      bit_cnt_q     <= '0;
      shadow_q      <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      bit_cnt_q     <= bit_cnt_d;
      shadow_q      <= shadow_d;
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (W=4): reset, clean and gapped frames,
// early sync, missing sync with resync, and reset in the middle of a frame.
module tb_tdm_demux4;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   fv_cnt;
  int   se_cnt;

  tdm_demux4_if #(.W(W)) bus ();

  tdm_demux4 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then sample outputs 1 time unit after the rising edge.
  task automatic send_bit(input logic v, input logic d, input logic fs);
    bus.din_valid  = v;
    bus.din        = d;
    bus.frame_sync = fs;
    @(posedge clk);
    #1;
    if (bus.frame_valid === 1'b1) fv_cnt++;
    if (bus.sync_err === 1'b1) se_cnt++;
    $display("t=%0t v=%b din=%b fs=%b -> dout=%h fv=%b locked=%b serr=%b",
             $time, v, d, fs, bus.dout, bus.frame_valid, bus.locked, bus.sync_err);
  endtask

  // Send frame bits first..last; bit i is channel i/4, MSB first.
  // frame_sync accompanies bit 0 when sync is set. gap idle cycles follow each bit.
  task automatic send_bits(input logic [15:0] word, input logic sync, input int gap,
                           input int first, input int last);
    logic [15:0] w;
    w = word;
    for (int i = first; i <= last; i++) begin
      send_bit(1'b1, w[(i / 4) * 4 + (3 - (i % 4))], sync && (i == 0));
      for (int g = 0; g < gap; g++) send_bit(1'b0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    fv_cnt   = 0;
    se_cnt   = 0;
    rst_n          = 1'b0;
    bus.din        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;

    // Reset with live-looking input
    for (int i = 0; i < 2; i++) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("reset_dout", 32'(bus.dout), 32'h0);
    check("reset_fv", 32'(bus.frame_valid), 32'h0);
    check("reset_locked", 32'(bus.locked), 32'h0);
    check("reset_serr", 32'(bus.sync_err), 32'h0);
    rst_n = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);

    // Clean back-to-back frame
    fv_cnt = 0; se_cnt = 0;
    send_bits(16'h3F5A, 1'b1, 0, 0, 0);
    check("clean_locked_after_sync", 32'(bus.locked), 32'h1);
    send_bits(16'h3F5A, 1'b1, 0, 1, 15);
    check("clean_dout", 32'(bus.dout), 32'h3F5A);
    check("clean_fv", 32'(bus.frame_valid), 32'h1);
    check("clean_locked", 32'(bus.locked), 32'h1);
    check("clean_fv_count", 32'(fv_cnt), 32'h1);
    send_bit(1'b0, 1'b0, 1'b0);
    check("clean_fv_one_cycle", 32'(bus.frame_valid), 32'h0);
    check("clean_dout_hold", 32'(bus.dout), 32'h3F5A);

    // Gapped input: 3 idle cycles after every bit
    fv_cnt = 0; se_cnt = 0;
    send_bits(16'h3F5A, 1'b1, 3, 0, 15);
    check("gap_dout", 32'(bus.dout), 32'h3F5A);
    check("gap_fv_count", 32'(fv_cnt), 32'h1);
    check("gap_serr_count", 32'(se_cnt), 32'h0);
    check("gap_locked", 32'(bus.locked), 32'h1);

    // Early sync after 6 bits
    fv_cnt = 0; se_cnt = 0;
    send_bits(16'h3F5A, 1'b1, 0, 0, 5);
    check("early_no_serr_yet", 32'(se_cnt), 32'h0);
    send_bits(16'h8421, 1'b1, 0, 0, 0);
    check("early_serr", 32'(bus.sync_err), 32'h1);
    check("early_dout_kept", 32'(bus.dout), 32'h3F5A);
    check("early_fv_low", 32'(bus.frame_valid), 32'h0);
    check("early_still_locked", 32'(bus.locked), 32'h1);
    send_bits(16'h8421, 1'b1, 0, 1, 14);
    check("early_no_frame_before_last", 32'(fv_cnt), 32'h0);
    send_bits(16'h8421, 1'b1, 0, 15, 15);
    check("early_dout", 32'(bus.dout), 32'h8421);
    check("early_fv", 32'(bus.frame_valid), 32'h1);
    check("early_serr_count", 32'(se_cnt), 32'h1);

    // Missing sync at the next frame start
    fv_cnt = 0; se_cnt = 0;
    send_bits(16'h1234, 1'b0, 0, 0, 0);
    check("miss_serr", 32'(bus.sync_err), 32'h1);
    check("miss_locked_drop", 32'(bus.locked), 32'h0);
    send_bits(16'h1234, 1'b0, 0, 1, 15);
    check("miss_ignored_fv", 32'(fv_cnt), 32'h0);
    check("miss_ignored_serr", 32'(se_cnt), 32'h1);
    check("miss_dout_kept", 32'(bus.dout), 32'h8421);
    check("miss_hunt", 32'(bus.locked), 32'h0);
    send_bits(16'h5A3C, 1'b1, 0, 0, 15);
    check("resync_dout", 32'(bus.dout), 32'h5A3C);
    check("resync_fv", 32'(bus.frame_valid), 32'h1);
    check("resync_locked", 32'(bus.locked), 32'h1);

    // Reset after 9 bits of a frame
    fv_cnt = 0; se_cnt = 0;
    send_bits(16'hFFFF, 1'b1, 0, 0, 8);
    rst_n = 1'b0;
    send_bit(1'b1, 1'b1, 1'b0);
    check("midrst_dout", 32'(bus.dout), 32'h0);
    check("midrst_locked", 32'(bus.locked), 32'h0);
    rst_n = 1'b1;
    send_bits(16'h100C, 1'b1, 0, 0, 15);
    check("midrst_frame_dout", 32'(bus.dout), 32'h100C);
    check("midrst_frame_fv", 32'(bus.frame_valid), 32'h1);
    check("midrst_fv_count", 32'(fv_cnt), 32'h1);
    check("midrst_serr_count", 32'(se_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
